ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Shares the single-port data/program RAM between the K&S core (port C) and a debug/loader
//  port (port D). Sits between control_unit/datapath address+write-enable outputs and the RAM.
//  Fixed priority to the core, with a starvation guard and a lock mode for multi-word debug
//  transfers. Registers read-response routing so each port sees its own data one cycle later.
// PARAMETERS
//  ADDR_W    5   RAM address width
//  DATA_W    16  RAM data width
//  MAX_WAIT  8   consecutive stalled cycles on D before D wins over C (1..255)
// PORTS
//  clk            in   1       clock, rising edge
//  rst_n          in   1       reset, asynchronous, active-low
//  c_req          in   1       core access request; held until c_gnt
//  c_we           in   1       core write (1) / read (0)
//  c_addr         in   ADDR_W  core address
//  c_wdata        in   DATA_W  core write data
//  c_gnt          out  1       core access accepted this cycle
//  c_rvalid       out  1       core read data valid (1 cycle after read grant)
//  c_rdata        out  DATA_W  core read data
//  d_req          in   1       debug access request; held until d_gnt
//  d_we           in   1       debug write/read
//  d_addr         in   ADDR_W  debug address
//  d_wdata        in   DATA_W  debug write data
//  d_lock         in   1       debug requests exclusive ownership
//  d_gnt          out  1       debug access accepted this cycle
//  d_rvalid       out  1       debug read data valid
//  d_rdata        out  DATA_W  debug read data
//  ram_addr       out  ADDR_W  RAM address
//  ram_we         out  1       RAM write enable
//  ram_wdata      out  DATA_W  RAM write data
//  ram_rdata      in   DATA_W  RAM read data, synchronous, 1-cycle latency
//  locked         out  1       D holds exclusive ownership
// BEHAVIOUR
//  - Grants, ram_addr/we/wdata combinational from state + requests; at most one gnt per cycle.
//  - FSM: S_SHARED, S_LOCKED. Reset -> S_SHARED, wait_cnt=0, rvalid regs=0, owner_q=C.
//  - While rst_n low: c_gnt=d_gnt=ram_we=c_rvalid=d_rvalid=locked=0, ram_addr=0.
//  - S_SHARED: D wins iff d_req && (!c_req || wait_cnt==MAX_WAIT); else C wins if c_req.
//  - wait_cnt: +1 each cycle d_req && !d_gnt, saturates at MAX_WAIT; cleared on d_gnt
//    or when d_req low.
//  - S_SHARED -> S_LOCKED when d_gnt && d_lock. In S_LOCKED only D can be granted
//    (c_gnt=0, core stalls); locked=1. S_LOCKED -> S_SHARED when d_lock low (checked
//    every cycle, no grant needed); the cycle d_lock drops, arbitration is as S_SHARED.
//  - No grant: ram_we=0, ram_addr/wdata hold port C values (don't-care for RAM).
//  - Read routing: on a read grant, owner_q<=granting port, rd_pend<=1. Next cycle the
//    owner's rvalid=1 and its rdata=ram_rdata; the other rvalid=0. Writes produce no rvalid.
//  - Back-to-back grants allowed every cycle; responses stay in grant order, 1-cycle latency.
//  - Asynchronous reset mid-transfer: pending rvalid dropped, lock released, counter cleared.
// TESTING
//  1 C read addr 3 alone -> c_gnt same cycle, ram_addr=3, c_rvalid next cycle with RAM[3].
//  2 C and D both req continuously, MAX_WAIT=8 -> C granted 8 cycles, D granted on 9th, repeat.
//  3 D write 0xA5A5 addr 7 with d_lock, then 3 reads while c_req high -> c_gnt=0 throughout,
//    locked=1; d_lock low -> C granted same cycle.
//  4 Alternating C read/D read every cycle -> c_rvalid/d_rvalid each exactly 1 cycle after own gnt.
//  5 C write then C read same addr next cycle -> read returns newly written value.
//  6 rst_n low during S_LOCKED with pending read -> locked=0, rvalids 0, wait_cnt 0 after release.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Arbitrates the single-port RAM between the core (port C) and the debug/loader port (port D).
// Core has fixed priority; a starvation counter and a lock mode let D get its transfers through.
module ram_port_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              d_lock,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              locked
);

    // Handshake: a port holds req (and its command fields) until gnt; gnt means the
    // access is issued to the RAM this cycle. A read grant yields rvalid exactly one
    // cycle later on the granted port only; write grants produce no response.

    typedef enum logic {S_SHARED, S_LOCKED} state_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  w_wait_nxt;
    logic        r_rd_pend;
    logic        r_owner_d;
    logic        w_c_gnt;
    logic        w_d_gnt;
    logic        w_eff_locked;
    logic        w_rd_gnt;

    always_comb begin
        w_state_nxt  = r_state;
        w_c_gnt      = 1'b0;
        w_d_gnt      = 1'b0;
        w_wait_nxt   = 8'd0;
        // Lock takes effect only while d_lock is still asserted; the release cycle arbitrates as shared.
        w_eff_locked = (r_state == S_LOCKED) && d_lock;

        if (w_eff_locked) begin
            w_d_gnt = d_req;
        end else begin
            w_d_gnt = d_req && (!c_req || (r_wait_cnt == MAX_WAIT_C));
            w_c_gnt = c_req && !w_d_gnt;
        end

        case (r_state)
            S_SHARED: if (w_d_gnt && d_lock) w_state_nxt = S_LOCKED;
            S_LOCKED: if (!d_lock)           w_state_nxt = S_SHARED;
            default:                         w_state_nxt = S_SHARED;
        endcase

        if (d_req && !w_d_gnt) begin
            w_wait_nxt = (r_wait_cnt == MAX_WAIT_C) ? MAX_WAIT_C : r_wait_cnt + 8'd1;
        end
    end

    assign w_rd_gnt = (w_c_gnt && !c_we) || (w_d_gnt && !d_we);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_SHARED;
            r_wait_cnt <= 8'd0;
            r_rd_pend  <= 1'b0;
            r_owner_d  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_rd_pend  <= w_rd_gnt;
            if (w_rd_gnt) r_owner_d <= w_d_gnt;
        end
    end

    // Combinational outputs are forced quiet while reset is held.
    assign c_gnt     = rst_n && w_c_gnt;
    assign d_gnt     = rst_n && w_d_gnt;
    assign locked    = rst_n && w_eff_locked;
    assign ram_addr  = !rst_n ? '0 : (w_d_gnt ? d_addr : c_addr);
    assign ram_we    = rst_n && (w_d_gnt ? d_we : (w_c_gnt && c_we));
    assign ram_wdata = w_d_gnt ? d_wdata : c_wdata;

    assign c_rvalid  = r_rd_pend && !r_owner_d;
    assign d_rvalid  = r_rd_pend && r_owner_d;
    assign c_rdata   = ram_rdata;
    assign d_rdata   = ram_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios, a bench-side RAM, and a per-cycle
// reference model of the arbitration rules with an expected-read-data queue.
module tb_ram_port_arbiter;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 16;
    localparam int MAX_WAIT = 8;
    localparam int DEPTH    = 1 << ADDR_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic              c_req, c_we, d_req, d_we, d_lock;
    logic [ADDR_W-1:0] c_addr, d_addr;
    logic [DATA_W-1:0] c_wdata, d_wdata;
    logic              c_gnt, c_rvalid, d_gnt, d_rvalid, ram_we, locked;
    logic [DATA_W-1:0] c_rdata, d_rdata, ram_wdata;
    logic [DATA_W-1:0] ram_rdata = '0;
    logic [ADDR_W-1:0] ram_addr;

    ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_lock(d_lock),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .locked(locked)
    );

    // Synchronous single-port RAM, one-cycle read latency.
    logic [DATA_W-1:0] ram_mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    logic [DATA_W-1:0] exp_mem [DEPTH];
    logic [DATA_W-1:0] exp_q [$];
    bit                own_q [$];   // 1 = response belongs to D
    bit                m_locked = 1'b0;
    int                m_wait   = 0;

    // Reference model: evaluated away from the active edge, once per cycle.
    always @(negedge clk) begin
        bit                eg_c, eg_d, exp_we, eff_lock, rsp_d, rsp_v;
        logic [ADDR_W-1:0] exp_addr;
        logic [DATA_W-1:0] rsp_data;
        if (!rst_n) begin
            chk("rst_c_gnt", c_gnt, 0);
            chk("rst_d_gnt", d_gnt, 0);
            chk("rst_ram_we", ram_we, 0);
            chk("rst_ram_addr", ram_addr, 0);
            chk("rst_c_rvalid", c_rvalid, 0);
            chk("rst_d_rvalid", d_rvalid, 0);
            chk("rst_locked", locked, 0);
            m_locked = 1'b0;
            m_wait   = 0;
            exp_q.delete();
            own_q.delete();
        end else begin
            eff_lock = m_locked && d_lock;
            if (eff_lock) begin
                eg_d = d_req;
                eg_c = 1'b0;
            end else begin
                eg_d = d_req && (!c_req || m_wait >= MAX_WAIT);
                eg_c = c_req && !eg_d;
            end
            exp_addr = eg_d ? d_addr : c_addr;
            exp_we   = eg_d ? d_we : (eg_c && c_we);
            chk("m_c_gnt", c_gnt, eg_c);
            chk("m_d_gnt", d_gnt, eg_d);
            chk("m_locked", locked, eff_lock);
            chk("m_ram_addr", ram_addr, exp_addr);
            chk("m_ram_we", ram_we, exp_we);
            if (exp_we) chk("m_ram_wdata", ram_wdata, eg_d ? d_wdata : c_wdata);

            rsp_v = (own_q.size() != 0);
            rsp_d = 1'b0;
            rsp_data = '0;
            if (rsp_v) begin
                rsp_d    = own_q.pop_front();
                rsp_data = exp_q.pop_front();
            end
            chk("m_c_rvalid", c_rvalid, rsp_v && !rsp_d);
            chk("m_d_rvalid", d_rvalid, rsp_v && rsp_d);
            if (rsp_v && !rsp_d) chk("m_c_rdata", c_rdata, rsp_data);
            if (rsp_v && rsp_d)  chk("m_d_rdata", d_rdata, rsp_data);

            if ((eg_c || eg_d) && !exp_we) begin
                own_q.push_back(eg_d);
                exp_q.push_back(exp_mem[exp_addr]);
            end
            if (exp_we) exp_mem[exp_addr] = eg_d ? d_wdata : c_wdata;

            m_wait   = (d_req && !eg_d) ? ((m_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wait + 1) : 0;
            m_locked = d_lock && (m_locked || eg_d);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_lock = 0;
    endtask

    task automatic set_c(input bit req, input bit we, input int addr, input logic [DATA_W-1:0] wd);
        c_req = req; c_we = we; c_addr = ADDR_W'(addr); c_wdata = wd;
    endtask

    task automatic set_d(input bit req, input bit we, input int addr, input logic [DATA_W-1:0] wd, input bit lk);
        d_req = req; d_we = we; d_addr = ADDR_W'(addr); d_wdata = wd; d_lock = lk;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram_mem[i] = DATA_W'(16'h1000 + i);
            exp_mem[i] = DATA_W'(16'h1000 + i);
        end
        idle();
        rst_n = 1'b0;
        c_req = 1; d_req = 1;
        @(negedge clk);
        chk("reset_c_gnt_held", c_gnt, 0);
        chk("reset_d_gnt_held", d_gnt, 0);
        tick();
        rst_n = 1'b1;
        idle();
        tick();

        // 1: lone core read of address 3
        set_c(1, 0, 3, '0);
        @(negedge clk);
        chk("t1_c_gnt", c_gnt, 1);
        chk("t1_ram_addr", ram_addr, 3);
        tick();
        idle();
        @(negedge clk);
        chk("t1_c_rvalid", c_rvalid, 1);
        chk("t1_c_rdata", c_rdata, 16'h1003);
        tick();

        // 2: both ports request continuously; D wins once every MAX_WAIT+1 cycles
        set_c(1, 0, 1, '0);
        set_d(1, 0, 2, '0, 0);
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            chk("t2_d_gnt", d_gnt, (i == 8 || i == 17));
            chk("t2_c_gnt", c_gnt, !(i == 8 || i == 17));
            tick();
        end
        idle();
        tick();
        tick();

        // 3: locked debug write followed by three reads while the core waits
        set_d(1, 1, 7, 16'hA5A5, 1);
        @(negedge clk);
        chk("t3_wr_gnt", d_gnt, 1);
        tick();
        set_c(1, 0, 5, '0);
        for (int i = 0; i < 3; i++) begin
            set_d(1, 0, (i == 1) ? 6 : 7, '0, 1);
            @(negedge clk);
            chk("t3_c_stall", c_gnt, 0);
            chk("t3_locked", locked, 1);
            chk("t3_d_gnt", d_gnt, 1);
            if (i == 1) chk("t3_rdata0", d_rdata, 16'hA5A5);
            if (i == 2) chk("t3_rdata1", d_rdata, 16'h1006);
            tick();
        end
        set_d(0, 0, 0, '0, 0);
        @(negedge clk);
        chk("t3_release_c_gnt", c_gnt, 1);
        chk("t3_release_locked", locked, 0);
        chk("t3_rdata2", d_rdata, 16'hA5A5);
        tick();
        idle();
        tick();

        // 4: alternating core / debug reads every cycle
        for (int i = 0; i < 8; i++) begin
            idle();
            if (i % 2 == 0) set_c(1, 0, 10 + i, '0);
            else            set_d(1, 0, 10 + i, '0, 0);
            @(negedge clk);
            chk("t4_c_gnt", c_gnt, (i % 2 == 0));
            chk("t4_d_gnt", d_gnt, (i % 2 == 1));
            chk("t4_c_rvalid", c_rvalid, (i > 0) && ((i - 1) % 2 == 0));
            chk("t4_d_rvalid", d_rvalid, (i > 0) && ((i - 1) % 2 == 1));
            tick();
        end
        idle();
        tick();

        // 5: core write then read of the same address
        set_c(1, 1, 9, 16'h1234);
        tick();
        set_c(1, 0, 9, '0);
        tick();
        idle();
        @(negedge clk);
        chk("t5_c_rvalid", c_rvalid, 1);
        chk("t5_c_rdata", c_rdata, 16'h1234);
        tick();

        // 6: reset while locked with a read in flight
        set_d(1, 0, 4, '0, 1);
        tick();
        set_c(1, 0, 1, '0);
        set_d(1, 0, 5, '0, 1);
        @(negedge clk);
        chk("t6_locked_before", locked, 1);
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_locked", locked, 0);
        chk("t6_rst_d_rvalid", d_rvalid, 0);
        tick();
        rst_n = 1'b1;
        set_d(1, 0, 6, '0, 1);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("t6_c_gnt", c_gnt, (i < 8));
            chk("t6_d_gnt", d_gnt, (i == 8));
            chk("t6_locked", locked, 0);
            chk("t6_d_rvalid", d_rvalid, 0);
            tick();
        end
        idle();
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
